mem_port_arbiter: RTL and testbench

Shares the single main-memory line port between two cache controllers: requester 0 is the data cache and requester 1 is the instruction cache. The arbiter picks one requester at a time using round-robin priority. It latches that requester's command, drives the memory port until `mem_ack`, and routes the response back. A timeout counter aborts any transaction the memory never acknowledges.

---
 rtl/cache_defs.sv | 29 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_defs.sv
// ============================================================================
//  Module   : cache_defs (package)
//  Brief    : Shared types and constants for the cache / memory-port slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_defs;

  localparam int MEM_TIMEOUT_DEFAULT = 64;
  localparam int CACHE_ADDR_WIDTH    = 32;
  localparam int CACHE_LINE_WIDTH    = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Command at the default slice widths.
  typedef struct packed {
    logic                        we;
    logic [CACHE_ADDR_WIDTH-1:0] addr;
    logic [CACHE_LINE_WIDTH-1:0] wdata;
  } mem_cmd_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
//  Module   : rr_pick2
//  Brief    : Two-way round-robin pick; on contention the non-last grantee wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (req == 2'b11) ? ~last_gnt : req[1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Round-robin share of one memory line port between D- and I-cache,
//             with a no-ack timeout. All outputs registered.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import cache_defs::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int TIMEOUT    = MEM_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req,
  input  logic [1:0]                 req_we,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][LINE_WIDTH-1:0] req_wdata,
  output logic [1:0]                 gnt,
  output logic [1:0]                 resp_valid,
  output logic                       resp_err,
  output logic [LINE_WIDTH-1:0]      resp_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [LINE_WIDTH-1:0]      mem_wdata,
  input  logic [LINE_WIDTH-1:0]      mem_rdata,
  input  logic                       mem_ack,
  output logic                       busy
);

  localparam int             CW         = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  C_CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t            r_state,      w_state_n;
  logic                  r_last_gnt,   w_last_gnt_n;
  logic                  r_owner,      w_owner_n;
  logic [CW-1:0]         r_cnt,        w_cnt_n;
  logic [1:0]            r_gnt,        w_gnt_n;
  logic [1:0]            r_resp_valid, w_resp_valid_n;
  logic                  r_resp_err,   w_resp_err_n;
  logic [LINE_WIDTH-1:0] r_resp_rdata, w_resp_rdata_n;
  logic                  r_mem_req,    w_mem_req_n;
  logic                  r_mem_we,     w_mem_we_n;
  logic [ADDR_WIDTH-1:0] r_mem_addr,   w_mem_addr_n;
  logic [LINE_WIDTH-1:0] r_mem_wdata,  w_mem_wdata_n;
  logic                  r_busy,       w_busy_n;
  logic                  w_pick_valid;
  logic                  w_pick_winner;

  rr_pick2 u_pick (
    .req      (req),
    .last_gnt (r_last_gnt),
    .valid    (w_pick_valid),
    .winner   (w_pick_winner)
  );

  // The mem_* registers double as the latched command register.
  always_comb begin
    w_state_n      = r_state;
    w_last_gnt_n   = r_last_gnt;
    w_owner_n      = r_owner;
    w_cnt_n        = r_cnt;
    w_gnt_n        = 2'b00;
    w_resp_valid_n = 2'b00;
    w_resp_err_n   = r_resp_err;
    w_resp_rdata_n = r_resp_rdata;
    w_mem_req_n    = 1'b0;
    w_mem_we_n     = r_mem_we;
    w_mem_addr_n   = r_mem_addr;
    w_mem_wdata_n  = r_mem_wdata;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_n[w_pick_winner] = 1'b1;
          w_last_gnt_n           = w_pick_winner;
          w_owner_n              = w_pick_winner;
          w_mem_we_n             = req_we[w_pick_winner];
          w_mem_addr_n           = req_addr[w_pick_winner];
          w_mem_wdata_n          = req_wdata[w_pick_winner];
          w_mem_req_n            = 1'b1;
          w_cnt_n                = '0;
          w_state_n              = MEM;
        end
      end
      MEM: begin
        w_mem_req_n = 1'b1;
        // An ack on the final timeout cycle still completes normally.
        if (mem_ack) begin
          w_resp_valid_n[r_owner] = 1'b1;
          w_resp_err_n            = 1'b0;
          w_resp_rdata_n          = r_mem_we ? '0 : mem_rdata;
          w_mem_req_n             = 1'b0;
          w_state_n               = RESP;
        end else if (r_cnt == C_CNT_LAST) begin
          w_resp_valid_n[r_owner] = 1'b1;
          w_resp_err_n            = 1'b1;
          w_resp_rdata_n          = '0;
          w_mem_req_n             = 1'b0;
          w_state_n               = RESP;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
    w_busy_n = (w_state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_gnt   <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_gnt        <= 2'b00;
      r_resp_valid <= 2'b00;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_last_gnt   <= w_last_gnt_n;
      r_owner      <= w_owner_n;
      r_cnt        <= w_cnt_n;
      r_gnt        <= w_gnt_n;
      r_resp_valid <= w_resp_valid_n;
      r_resp_err   <= w_resp_err_n;
      r_resp_rdata <= w_resp_rdata_n;
      r_mem_req    <= w_mem_req_n;
      r_mem_we     <= w_mem_we_n;
      r_mem_addr   <= w_mem_addr_n;
      r_mem_wdata  <= w_mem_wdata_n;
      r_busy       <= w_busy_n;
    end
  end

  assign gnt        = r_gnt;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed-vector bench for mem_port_arbiter (TIMEOUT = 8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req;
  logic [1:0]          req_we;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][LW-1:0]  req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          resp_valid;
  logic                resp_err;
  logic [LW-1:0]       resp_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [LW-1:0]       mem_wdata;
  logic [LW-1:0]       mem_rdata;
  logic                mem_ack;
  logic                busy;

  int n_vectors     = 0;
  int n_miscompares = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam logic [LW-1:0] RD1   = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [LW-1:0] WD1   = {4{32'hCBCBDFDF}};
  localparam logic [LW-1:0] RD5   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LW-1:0] JUNK  = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  logic [1:0] gw [4];
  int         gc [4];
  int         ngr;
  int         mcnt;
  int         k;

  initial begin
    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick();
    tick();
    chk_vec("rst_gnt",        LW'(gnt),        LW'(2'b00));
    chk_vec("rst_resp_valid", LW'(resp_valid), LW'(2'b00));
    chk_vec("rst_mem_req",    LW'(mem_req),    LW'(1'b0));
    chk_vec("rst_busy",       LW'(busy),       LW'(1'b0));
    chk_vec("rst_mem_addr",   LW'(mem_addr),   '0);
    chk_vec("rst_resp_rdata", resp_rdata,      '0);

    // Test 1: requester 0 read, ack 2 cycles after mem_req rises.
    reset = 1'b0;
    req = 2'b01; req_we = 2'b00; req_addr[0] = 32'h0000_1230;
    tick();
    chk_vec("t1_gnt",      LW'(gnt),      LW'(2'b01));
    chk_vec("t1_mem_req",  LW'(mem_req),  LW'(1'b1));
    chk_vec("t1_mem_addr", LW'(mem_addr), LW'(32'h0000_1230));
    chk_vec("t1_mem_we",   LW'(mem_we),   LW'(1'b0));
    req = 2'b00;
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = RD1;
    tick();
    mem_ack = 1'b0; mem_rdata = JUNK;
    chk_vec("t1_resp_valid", LW'(resp_valid), LW'(2'b01));
    chk_vec("t1_resp_rdata", resp_rdata,      RD1);
    chk_vec("t1_resp_err",   LW'(resp_err),   LW'(1'b0));
    chk_vec("t1_mem_req_lo", LW'(mem_req),    LW'(1'b0));
    tick();

    // Test 2: requester 1 write; command must stay stable while the source changes.
    req = 2'b10; req_we = 2'b10; req_addr[1] = 32'h0000_0340; req_wdata[1] = WD1;
    tick();
    chk_vec("t3_gnt",      LW'(gnt),      LW'(2'b10));
    chk_vec("t3_mem_we",   LW'(mem_we),   LW'(1'b1));
    chk_vec("t3_mem_addr", LW'(mem_addr), LW'(32'h0000_0340));
    chk_vec("t3_wdata_c1", mem_wdata,     WD1);
    req = 2'b00; req_we = 2'b00; req_wdata[1] = JUNK; req_addr[1] = 32'hFFFF_FFF0;
    tick();
    chk_vec("t3_wdata_c2", mem_wdata,   WD1);
    chk_vec("t3_we_c2",    LW'(mem_we), LW'(1'b1));
    tick();
    chk_vec("t3_wdata_c3", mem_wdata,   WD1);
    chk_vec("t3_addr_c3",  LW'(mem_addr), LW'(32'h0000_0340));
    mem_ack = 1'b1; mem_rdata = JUNK;
    tick();
    mem_ack = 1'b0;
    chk_vec("t3_resp_valid", LW'(resp_valid), LW'(2'b10));
    chk_vec("t3_resp_rdata", resp_rdata,      '0);
    chk_vec("t3_resp_err",   LW'(resp_err),   LW'(1'b0));
    tick();

    // Test 3: both requesting, each access acked in its second MEM cycle.
    req = 2'b11; req_we = 2'b00; ngr = 0; mcnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt != 2'b00) begin
        if (ngr < 4) begin
          gw[ngr] = gnt;
          gc[ngr] = c;
        end
        ngr++;
        if (ngr == 4) req = 2'b00;
      end
      if (mem_req) begin
        mcnt++;
        mem_ack = (mcnt == 2);
      end else begin
        mcnt    = 0;
        mem_ack = 1'b0;
      end
    end
    mem_ack = 1'b0;
    chk_vec("t2_ngrants", LW'(ngr), LW'(4));
    if (ngr >= 4) begin
      for (int i = 0; i < 4; i++)
        chk_vec($sformatf("t2_order%0d", i), LW'(gw[i]), LW'((i % 2 == 0) ? 2'b01 : 2'b10));
      for (int i = 1; i < 4; i++)
        chk_vec($sformatf("t2_space%0d", i), LW'(gc[i] - gc[i-1]), LW'(4));
    end
    chk_vec("t2_idle", LW'(busy), LW'(1'b0));

    // Test 4: no ack, timeout TO cycles after the grant.
    req = 2'b01; req_we = 2'b00; req_addr[0] = 32'h0000_2000;
    tick();
    chk_vec("t4_gnt", LW'(gnt), LW'(2'b01));
    req = 2'b00;
    k = 0;
    while (k < 20) begin
      tick();
      k++;
      if (resp_valid != 2'b00) break;
    end
    chk_vec("t4_latency",    LW'(k),          LW'(TO));
    chk_vec("t4_resp_valid", LW'(resp_valid), LW'(2'b01));
    chk_vec("t4_resp_err",   LW'(resp_err),   LW'(1'b1));
    chk_vec("t4_resp_rdata", resp_rdata,      '0);
    chk_vec("t4_mem_req",    LW'(mem_req),    LW'(1'b0));
    tick();
    chk_vec("t4_mem_req_after", LW'(mem_req), LW'(1'b0));
    tick();

    // Test 5: ack lands on the final timeout cycle.
    req = 2'b10; req_we = 2'b00; req_addr[1] = 32'h0000_3000;
    tick();
    chk_vec("t5_gnt", LW'(gnt), LW'(2'b10));
    req = 2'b00;
    for (int i = 0; i < TO - 1; i++) tick();
    chk_vec("t5_no_early_resp", LW'(resp_valid), LW'(2'b00));
    mem_ack = 1'b1; mem_rdata = RD5;
    tick();
    mem_ack = 1'b0;
    chk_vec("t5_resp_valid", LW'(resp_valid), LW'(2'b10));
    chk_vec("t5_resp_err",   LW'(resp_err),   LW'(1'b0));
    chk_vec("t5_resp_rdata", resp_rdata,      RD5);
    tick();

    // Test 6: reset during the second MEM cycle of a write.
    req = 2'b01; req_we = 2'b01; req_addr[0] = 32'h0000_4440; req_wdata[0] = WD1;
    tick();
    chk_vec("t6_gnt", LW'(gnt), LW'(2'b01));
    req = 2'b00;
    tick();
    reset = 1'b1; req = 2'b11; req_we = 2'b00;
    tick();
    chk_vec("t6_rst_gnt",        LW'(gnt),        LW'(2'b00));
    chk_vec("t6_rst_resp_valid", LW'(resp_valid), LW'(2'b00));
    chk_vec("t6_rst_resp_err",   LW'(resp_err),   LW'(1'b0));
    chk_vec("t6_rst_mem_req",    LW'(mem_req),    LW'(1'b0));
    chk_vec("t6_rst_mem_we",     LW'(mem_we),     LW'(1'b0));
    chk_vec("t6_rst_mem_addr",   LW'(mem_addr),   '0);
    chk_vec("t6_rst_mem_wdata",  mem_wdata,       '0);
    chk_vec("t6_rst_busy",       LW'(busy),       LW'(1'b0));
    reset = 1'b0;
    tick();
    chk_vec("t6_first_gnt", LW'(gnt), LW'(2'b01));
    req = 2'b00;
    mem_ack = 1'b1; mem_rdata = RD1;
    tick();
    mem_ack = 1'b0;
    chk_vec("t6_resp_valid", LW'(resp_valid), LW'(2'b01));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

`default_nettype wire
